// File: rtl/baopoco_quant_gain_eq.sv
// baopoco_quant_gain_eq: scales complex samples by a double-buffered gain, rounds and
// saturates each component to 4-bit signed, packs the pair and counts clipped samples
// per spectrum.
//   user_clk    in   block clock
//   user_rst    in   asynchronous active-high reset
//   gain_word   in   gain register word, low GAIN_W bits used
//   sync_in     in   spectrum sync pulse, loads gain_word into the active gain
//   din_valid   in   input sample valid
//   din_re/im   in   signed DIN_W-bit components
//   dout        out  {re4, im4} two's complement nibbles, held while invalid
//   dout_valid  out  dout valid, 4 cycles after din_valid
//   sync_out    out  sync_in delayed by 4 cycles
//   gain_active out  gain currently applied to new samples
//   clip_count  out  clipped-sample count of the previous complete spectrum
module baopoco_quant_gain_eq #(
    parameter int DIN_W     = 18,
    parameter int GAIN_W    = 16,
    parameter int GAIN_BP   = 10,
    parameter int GAIN_RST  = 1024,
    parameter int OUT_SHIFT = 24
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       gain_word,
    input  logic              sync_in,
    input  logic              din_valid,
    input  logic [DIN_W-1:0]  din_re,
    input  logic [DIN_W-1:0]  din_im,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              sync_out,
    output logic [GAIN_W-1:0] gain_active,
    output logic [31:0]       clip_count
);
    localparam int PW = DIN_W + GAIN_W;
    // one guard bit so the rounding add cannot overflow at full-scale gain
    localparam int RW = PW + 1 - OUT_SHIFT;
    localparam logic signed [PW:0] HALF = (PW + 1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [RW-1:0] P7 = RW'(7);
    localparam logic signed [RW-1:0] N7 = RW'(-7);
    logic unused_gain_bits;
    assign unused_gain_bits = ^gain_word[31:GAIN_W];
    logic [GAIN_W-1:0]        gain_q, g1_q;
    logic signed [DIN_W-1:0]  re1_q, im1_q;
    logic signed [PW-1:0]     pre_q, pim_q, pre_d, pim_d;
    logic signed [PW:0]       sre_d, sim_d;
    logic signed [RW-1:0]     rre_q, rim_q, rre_d, rim_d;
    logic [3:0]               v_q, s_q;
    logic [7:0]               dout_q, dout_d;
    logic                     clip_q, clip_d, cre_d, cim_d;
    logic [31:0]              run_q, cc_q;
    function automatic logic [3:0] sat4(input logic signed [RW-1:0] x);
        return x > P7 ? 4'h7 : x < N7 ? 4'h9 : x[3:0];
    endfunction
    always_comb begin
        pre_d  = PW'(re1_q) * PW'($signed({1'b0, g1_q}));
        pim_d  = PW'(im1_q) * PW'($signed({1'b0, g1_q}));
        sre_d  = (PW + 1)'(pre_q) + HALF;
        sim_d  = (PW + 1)'(pim_q) + HALF;
        rre_d  = RW'(sre_d >>> OUT_SHIFT);
        rim_d  = RW'(sim_d >>> OUT_SHIFT);
        cre_d  = rre_q > P7 || rre_q < N7;
        cim_d  = rim_q > P7 || rim_q < N7;
        clip_d = v_q[2] && (cre_d || cim_d);
        dout_d = v_q[2] ? {sat4(rre_q), sat4(rim_q)} : dout_q;
    end
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            gain_q <= GAIN_W'(GAIN_RST);
            g1_q   <= '0;
            re1_q  <= '0;
            im1_q  <= '0;
            pre_q  <= '0;
            pim_q  <= '0;
            rre_q  <= '0;
            rim_q  <= '0;
            v_q    <= '0;
            s_q    <= '0;
            dout_q <= '0;
            clip_q <= 1'b0;
            run_q  <= '0;
            cc_q   <= '0;
        end else begin
            // sample entering with sync still picks up the old gain via g1_q
            gain_q <= sync_in ? gain_word[GAIN_W-1:0] : gain_q;
            g1_q   <= gain_q;
            re1_q  <= din_re;
            im1_q  <= din_im;
            pre_q  <= pre_d;
            pim_q  <= pim_d;
            rre_q  <= rre_d;
            rim_q  <= rim_d;
            v_q    <= {v_q[2:0], din_valid};
            s_q    <= {s_q[2:0], sync_in};
            dout_q <= dout_d;
            clip_q <= clip_d;
            // counter observes the S4 output stage; a sample alongside sync_out opens the new spectrum
            if (s_q[3]) begin
                cc_q  <= run_q;
                run_q <= {31'd0, clip_q};
            end else if (clip_q && run_q != 32'hFFFF_FFFF) begin
                run_q <= run_q + 32'd1;
            end
        end
    end
    assign dout        = dout_q;
    assign dout_valid  = v_q[3];
    assign sync_out    = s_q[3];
    assign gain_active = gain_q;
    assign clip_count  = cc_q;
endmodule

// File: tb/tb_baopoco_quant_gain_eq.sv
// tb_baopoco_quant_gain_eq: randomized and directed bench against an arithmetic reference model.
module tb_baopoco_quant_gain_eq;
    logic              user_clk = 1'b0;
    logic              user_rst;
    logic [31:0]       gain_word;
    logic              sync_in, din_valid;
    logic [17:0]       din_re, din_im;
    logic [7:0]        dout;
    logic              dout_valid, sync_out;
    logic [15:0]       gain_active;
    logic [31:0]       clip_count;
    int errors = 0;
    int checks = 0;
    baopoco_quant_gain_eq dut (
        .user_clk(user_clk), .user_rst(user_rst), .gain_word(gain_word), .sync_in(sync_in),
        .din_valid(din_valid), .din_re(din_re), .din_im(din_im), .dout(dout),
        .dout_valid(dout_valid), .sync_out(sync_out), .gain_active(gain_active),
        .clip_count(clip_count)
    );
    always #5 user_clk = ~user_clk;
    typedef struct {
        bit       v;
        bit       s;
        bit [3:0] re;
        bit [3:0] im;
        bit       c;
    } ent_t;
    ent_t     q[$];
    ent_t     prev;
    bit [7:0] m_dout;
    bit       m_v, m_s;
    bit [15:0] m_gain;
    longint   m_run, m_cc;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask
    // value * gain / 2^24, rounded half up (floor of x + 0.5), clamped to [-7, 7]
    function automatic longint quant(input longint x, input longint g, output bit clip);
        longint num;
        longint qv;
        num = x * g + 64'sd8388608;
        qv = num / 64'sd16777216;
        if (num < 0 && (num % 64'sd16777216) != 0) qv = qv - 1;
        clip = (qv > 7) || (qv < -7);
        return qv > 7 ? 7 : (qv < -7 ? -7 : qv);
    endfunction
    task automatic model_reset();
        q.delete();
        m_dout = 0;
        m_v = 0;
        m_s = 0;
        m_gain = 16'd1024;
        m_run = 0;
        m_cc = 0;
        prev = '{default: 0};
    endtask
    task automatic step(input bit s, input bit v, input int re, input int im, input int gw);
        ent_t e, o;
        bit cr, ci;
        longint r4, i4;
        sync_in = s;
        din_valid = v;
        din_re = 18'(re);
        din_im = 18'(im);
        gain_word = gw;
        r4 = quant(longint'(re), longint'(m_gain), cr);
        i4 = quant(longint'(im), longint'(m_gain), ci);
        e.v = v;
        e.s = s;
        e.re = r4[3:0];
        e.im = i4[3:0];
        e.c = v && (cr || ci);
        q.push_back(e);
        if (s) m_gain = gw[15:0];
        @(posedge user_clk);
        #1;
        // clip_count follows the cycle in which sync reached the output
        if (prev.s) begin
            m_cc = m_run;
            m_run = prev.c ? 1 : 0;
        end else if (prev.c && m_run != 64'hFFFF_FFFF) begin
            m_run++;
        end
        o = '{default: 0};
        if (q.size() >= 4) o = q.pop_front();
        m_v = o.v;
        m_s = o.s;
        if (o.v) m_dout = {o.re, o.im};
        prev = o;
        check("dout", dout, m_dout);
        check("dout_valid", dout_valid, m_v);
        check("sync_out", sync_out, m_s);
        check("gain_active", gain_active, m_gain);
        check("clip_count", clip_count, m_cc[31:0]);
    endtask
    task automatic idle(input int n, input int gw);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, gw);
    endtask
    task automatic rand_run(input int n);
        int gw;
        int re, im;
        gw = 1024;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                gw = int'($urandom());
                gw[15:0] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(0, 6000));
            end
            if ($urandom_range(0, 1) == 0) begin
                re = int'($urandom_range(0, 262143)) - 131072;
                im = int'($urandom_range(0, 262143)) - 131072;
            end else begin
                re = int'($urandom_range(0, 65535)) - 32768;
                im = int'($urandom_range(0, 65535)) - 32768;
            end
            step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, re, im, gw);
        end
    endtask
    task automatic check_reset_state(input string tag);
        check({tag, "_dout"}, dout, 8'h00);
        check({tag, "_valid"}, dout_valid, 1'b0);
        check({tag, "_sync"}, sync_out, 1'b0);
        check({tag, "_clip"}, clip_count, 32'd0);
        check({tag, "_gain"}, gain_active, 16'd1024);
    endtask
    initial begin
        user_rst = 1'b1;
        gain_word = 32'd1024;
        sync_in = 1'b0;
        din_valid = 1'b0;
        din_re = '0;
        din_im = '0;
        model_reset();
        repeat (2) @(posedge user_clk);
        #1;
        check_reset_state("rst");
        user_rst = 1'b0;
        // basic scaling and sync latency
        step(1, 1, 32768, -32768, 1024);
        idle(2, 1024);
        check("t1_sync_early", sync_out, 1'b0);
        idle(1, 1024);
        check("t1_dout", dout, 8'h2E);
        check("t1_valid", dout_valid, 1'b1);
        check("t1_sync", sync_out, 1'b1);
        // round half up boundaries
        step(0, 1, 8192, 0, 1024);
        step(0, 1, -8192, 0, 1024);
        step(0, 1, 8191, 0, 1024);
        idle(1, 1024);
        check("t2_half_up", dout[7:4], 4'd1);
        idle(1, 1024);
        check("t2_neg_half", dout[7:4], 4'd0);
        idle(1, 1024);
        check("t2_below_half", dout[7:4], 4'd0);
        // saturation and clip counting
        step(1, 0, 0, 0, 4096);
        for (int i = 0; i < 4; i++) step(0, 1, 131071, -131072, 4096);
        check("t3_sat", dout, 8'h79);
        step(0, 1, 131071, -131072, 4096);
        step(1, 0, 0, 0, 4096);
        idle(3, 4096);
        check("t3_sync_out", sync_out, 1'b1);
        idle(1, 4096);
        check("t3_clip5", clip_count, 32'd5);
        // gain written mid-spectrum only takes effect at sync
        step(1, 0, 0, 0, 1024);
        step(0, 1, 32768, 0, 2048);
        idle(3, 2048);
        check("t4_old_gain", dout[7:4], 4'd2);
        check("t4_gain_hold", gain_active, 16'd1024);
        check("t4_clip_restart", clip_count, 32'd0);
        step(1, 0, 0, 0, 2048);
        check("t4_gain_new", gain_active, 16'd2048);
        step(0, 1, 32768, 0, 2048);
        idle(3, 2048);
        check("t4_new_gain", dout, 8'h40);
        // sync coinciding with a clipping sample
        step(0, 1, 131071, 0, 2048);
        step(0, 1, 131071, 0, 2048);
        step(1, 1, 131071, 0, 2048);
        idle(3, 2048);
        check("t6_sync_valid", {sync_out, dout_valid}, 2'b11);
        idle(1, 2048);
        check("t6_excl", clip_count, 32'd2);
        step(1, 0, 0, 0, 2048);
        idle(4, 2048);
        check("t6_carry", clip_count, 32'd1);
        // zero gain
        step(1, 0, 0, 0, 0);
        step(0, 1, 131071, -131072, 0);
        idle(3, 0);
        check("gain0_dout", dout, 8'h00);
        check("gain0_valid", dout_valid, 1'b1);
        rand_run(300);
        // asynchronous reset in the middle of a stream
        #2 user_rst = 1'b1;
        #1;
        check_reset_state("arst");
        repeat (2) @(posedge user_clk);
        #1;
        check_reset_state("arst_hold");
        user_rst = 1'b0;
        model_reset();
        step(1, 1, 65536, 65536, 1024);
        idle(2, 1024);
        check("arst_lat3", dout_valid, 1'b0);
        idle(1, 1024);
        check("arst_lat4", {dout_valid, dout}, {1'b1, 8'h44});
        rand_run(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
